// File: rtl/bp_pkg.sv
// Shared branch-predictor types: counter storage type, saturation bounds and
// the weakly-not-taken initial value used on reset.
package bp_pkg;

    localparam int unsigned CNT_MAX_WIDTH = 4;

    // Widest legal counter; modules narrow it to their own CNT_WIDTH.
    typedef logic [CNT_MAX_WIDTH-1:0] cnt_max_t;

    localparam cnt_max_t CNT_SAT_MIN = '0;

    function automatic cnt_max_t cnt_sat_max(int unsigned width);
        return cnt_max_t'((1 << width) - 1);
    endfunction

    function automatic cnt_max_t cnt_weak_nt(int unsigned width);
        return cnt_max_t'((1 << (width - 1)) - 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter next-state function; purely combinational.
module sat_counter
    import bp_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 2
) (
    input  logic [CNT_WIDTH-1:0] cnt,
    input  logic                 taken,
    output logic [CNT_WIDTH-1:0] next
);

    localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(cnt_sat_max(CNT_WIDTH));
    localparam logic [CNT_WIDTH-1:0] CntMin = CNT_WIDTH'(CNT_SAT_MIN);

    always_comb begin
        next = cnt;
        if (taken) begin
            if (cnt != CntMax) next = cnt + CNT_WIDTH'(1);
        end else begin
            if (cnt != CntMin) next = cnt - CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/gshare_history_table.sv
// Pattern history table of saturating counters indexed by PC, XOR-hashed with a
// speculative global history when GSHARE_HASH_EN is defined (bimodal otherwise).
module gshare_history_table
    import bp_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = 10,
    parameter int unsigned GHR_WIDTH   = 8,
    parameter int unsigned CNT_WIDTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   lookup_valid,
    input  logic [INDEX_WIDTH-1:0] lookup_pc,
    output logic                   pred_taken,
    output logic [INDEX_WIDTH-1:0] pred_index,
    output logic [GHR_WIDTH-1:0]   pred_ghr,
    input  logic                   update_valid,
    input  logic [INDEX_WIDTH-1:0] update_index,
    input  logic                   update_taken,
    input  logic                   update_mispredict,
    input  logic [GHR_WIDTH-1:0]   update_ghr,
    output logic [GHR_WIDTH-1:0]   ghr
);

    localparam int unsigned Depth = 1 << INDEX_WIDTH;

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    localparam cnt_t CntInit = CNT_WIDTH'(cnt_weak_nt(CNT_WIDTH));

    cnt_t                 pht_q [Depth];
    logic [GHR_WIDTH-1:0] ghr_q, ghr_d;
    cnt_t                 upd_cur, upd_next, lkp_cnt;
    logic                 bypass;
    logic [GHR_WIDTH-1:0] ghr_repair, ghr_shift;

`ifdef GSHARE_HASH_EN
    assign pred_index = lookup_pc ^ INDEX_WIDTH'(ghr_q);
`else
    assign pred_index = lookup_pc;
`endif

    assign upd_cur = pht_q[update_index];
    assign lkp_cnt = pht_q[pred_index];

    sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_sat_counter (
        .cnt   (upd_cur),
        .taken (update_taken),
        .next  (upd_next)
    );

    // Same-cycle update to the looked-up entry forwards the post-update value.
    assign bypass     = update_valid && (update_index == pred_index);
    assign pred_taken = bypass ? upd_next[CNT_WIDTH-1] : lkp_cnt[CNT_WIDTH-1];
    assign pred_ghr   = ghr_q;
    assign ghr        = ghr_q;

    if (GHR_WIDTH == 1) begin : g_ghr_narrow
        assign ghr_repair = update_taken;
        assign ghr_shift  = pred_taken;
    end else begin : g_ghr_wide
        assign ghr_repair = {update_ghr[GHR_WIDTH-2:0], update_taken};
        assign ghr_shift  = {ghr_q[GHR_WIDTH-2:0], pred_taken};
    end

    // Oldest history bit of the snapshot falls off the end during repair.
    logic unused_update_ghr_msb;
    assign unused_update_ghr_msb = update_ghr[GHR_WIDTH-1];

    always_comb begin
        ghr_d = ghr_q;
        if (update_valid && update_mispredict) begin
            ghr_d = ghr_repair;
        end else if (lookup_valid) begin
            ghr_d = ghr_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q <= '0;
        end else if (en) begin
            ghr_q <= ghr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                pht_q[i] <= CntInit;
            end
        end else if (en && update_valid) begin
            pht_q[update_index] <= upd_next;
        end
    end

endmodule

// File: tb/tb_gshare_history_table.sv
// Directed bench for gshare_history_table; expectations are queued by the
// stimulus and compared by a separate monitor at the falling clock edge.
module tb_gshare_history_table;

    localparam int unsigned IW = 10;
    localparam int unsigned GW = 8;

    logic          clk = 1'b0;
    logic          rst, en, lookup_valid, update_valid, update_taken, update_mispredict;
    logic [IW-1:0] lookup_pc, update_index, pred_index;
    logic [GW-1:0] update_ghr, pred_ghr, ghr;
    logic          pred_taken;

    gshare_history_table #(
        .INDEX_WIDTH (IW),
        .GHR_WIDTH   (GW),
        .CNT_WIDTH   (2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .en                (en),
        .lookup_valid      (lookup_valid),
        .lookup_pc         (lookup_pc),
        .pred_taken        (pred_taken),
        .pred_index        (pred_index),
        .pred_ghr          (pred_ghr),
        .update_valid      (update_valid),
        .update_index      (update_index),
        .update_taken      (update_taken),
        .update_mispredict (update_mispredict),
        .update_ghr        (update_ghr),
        .ghr               (ghr)
    );

    always #5 clk = ~clk;

    typedef enum int {KPred, KIdx, KGhr, KPghr} kind_e;
    typedef struct {
        string       name;
        kind_e       kind;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [IW-1:0] hash(logic [IW-1:0] pc, logic [GW-1:0] g);
`ifdef GSHARE_HASH_EN
        return pc ^ IW'(g);
`else
        return pc;
`endif
    endfunction

    task automatic expect_val(string name, kind_e kind, logic [31:0] val);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic expect_lookup(string name, logic p, logic [IW-1:0] idx, logic [GW-1:0] g);
        expect_val({name, "_pred"}, KPred, 32'(p));
        expect_val({name, "_idx"}, KIdx, 32'(idx));
        expect_val({name, "_pghr"}, KPghr, 32'(g));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: lookup outputs are combinational, so every queued entry for the
    // current cycle is checked mid-cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = exp_q.pop_front();
            unique case (e.kind)
                KPred:   act = 32'(pred_taken);
                KIdx:    act = 32'(pred_index);
                KGhr:    act = 32'(ghr);
                default: act = 32'(pred_ghr);
            endcase
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val);
            end
        end
    end

    initial begin
        logic [IW-1:0] pc;
        rst = 1'b1; en = 1'b1; lookup_valid = 1'b0; lookup_pc = '0;
        update_valid = 1'b0; update_index = '0; update_taken = 1'b0;
        update_mispredict = 1'b0; update_ghr = '0;
        cyc();
        cyc();

        rst = 1'b0;
        lookup_pc = 10'h155;
        expect_lookup("reset", 1'b0, 10'h155, 8'h00);
        expect_val("reset_ghr", KGhr, 32'h0);
        cyc();

        // Taken x3 at 0x155: 1->2->3->3, bypass visible each cycle.
        update_valid = 1'b1; update_index = 10'h155; update_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_val("sat_up_bypass", KPred, 32'h1);
            cyc();
        end
        update_valid = 1'b0;
        expect_val("sat_up_read", KPred, 32'h1);
        cyc();
        // Not-taken x2: 3->2 (still taken), 2->1 (not taken); a wrap would show here.
        update_valid = 1'b1; update_taken = 1'b0;
        expect_val("sat_dn_3to2", KPred, 32'h1);
        cyc();
        expect_val("sat_dn_2to1", KPred, 32'h0);
        cyc();

        // Bypass: update 0x0AA (1->2) concurrent with lookup to 0x0AA.
        update_index = 10'h0AA; update_taken = 1'b1; lookup_pc = 10'h0AA;
        expect_lookup("bypass", 1'b1, 10'h0AA, 8'h00);
        cyc();
        update_valid = 1'b0;
        expect_val("bypass_written", KPred, 32'h1);
        cyc();

        // History shift: predictions 1,0,1 from ghr=0.
        lookup_valid = 1'b1;
        lookup_pc = 10'h0AA;
        expect_lookup("hist1", 1'b1, 10'h0AA, 8'h00);
        cyc();
        lookup_pc = 10'h300;
        expect_lookup("hist2", 1'b0, hash(10'h300, 8'h01), 8'h01);
        cyc();
        pc = hash(10'h0AA, 8'h02);
        lookup_pc = pc;
        expect_lookup("hist3", 1'b1, 10'h0AA, 8'h02);
        cyc();
        lookup_valid = 1'b0;
        lookup_pc = 10'h100;
        expect_lookup("hist_hash", 1'b0, hash(10'h100, 8'h05), 8'h05);
        expect_val("hist_ghr", KGhr, 32'h05);
        cyc();

        // Repair to 0x3C, then mispredict with concurrent lookup -> 0x25.
        update_valid = 1'b1; update_mispredict = 1'b1; update_index = 10'h3FF;
        update_taken = 1'b0; update_ghr = 8'h1E;
        cyc();
        expect_val("repair_setup", KGhr, 32'h3C);
        update_index = 10'h3FE; update_taken = 1'b1; update_ghr = 8'h12;
        lookup_valid = 1'b1; lookup_pc = 10'h0AA;
        cyc();
        expect_val("repair_wins", KGhr, 32'h25);
        update_valid = 1'b0; lookup_valid = 1'b0; update_ghr = 8'hFF;
        cyc();
        expect_val("mispredict_gated", KGhr, 32'h25);
        update_mispredict = 1'b0;

        // Freeze: update 0x0AA not-taken plus lookup with en low.
        en = 1'b0; update_valid = 1'b1; update_index = 10'h0AA; update_taken = 1'b0;
        lookup_valid = 1'b1;
        cyc();
        en = 1'b1; update_valid = 1'b0; lookup_valid = 1'b0;
        pc = hash(10'h0AA, 8'h25);
        lookup_pc = pc;
        expect_lookup("freeze", 1'b1, 10'h0AA, 8'h25);
        expect_val("freeze_ghr", KGhr, 32'h25);
        cyc();

        // Reset overrides en low.
        rst = 1'b1; en = 1'b0;
        cyc();
        rst = 1'b0; en = 1'b1; lookup_pc = 10'h0AA;
        expect_lookup("rst_no_en", 1'b0, 10'h0AA, 8'h00);
        expect_val("rst_no_en_ghr", KGhr, 32'h0);
        cyc();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) cyc();
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gshare_history_table.md
# gshare_history_table

Parametrised successor to the 2-bit branch history table. Provides a pattern history table of saturating counters of configurable width, indexed by the fetch PC hashed with a speculative global history register (GHR). Includes same-cycle update/lookup bypass and GHR recovery on mispredict. Sits in the fetch stage, feeding the branch predictor; updates come back from the execute stage carrying the index and history snapshot captured at lookup.

## Interface
- `INDEX_WIDTH`, 10: table index width; depth = 2**INDEX_WIDTH entries.
- `GHR_WIDTH`, 8: global history length; legal range 1..INDEX_WIDTH.
- `CNT_WIDTH`, 2: counter width; legal range 1..4.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: pipeline advance; low freezes all state (table, GHR).
- `lookup_valid` in 1: fetch lookup this cycle.
- `lookup_pc` in INDEX_WIDTH: PC index bits.
- `pred_taken` out 1: MSB of the selected counter, after bypass.
- `pred_index` out INDEX_WIDTH: hashed index; the pipeline carries it to the update port.
- `pred_ghr` out GHR_WIDTH: GHR value before this lookup's shift (snapshot).
- `update_valid` in 1: resolved branch.
- `update_index` in INDEX_WIDTH: `pred_index` captured at lookup.
- `update_taken` in 1: actual outcome.
- `update_mispredict` in 1: direction mispredicted; triggers GHR repair.
- `update_ghr` in GHR_WIDTH: `pred_ghr` captured at lookup.
- `ghr` out GHR_WIDTH: current speculative GHR.

## Operation
- Hash: `pred_index = lookup_pc ^ {{(INDEX_WIDTH-GHR_WIDTH){1'b0}}, ghr}`.
- Counters are unsigned CNT_WIDTH-bit values and saturate:
  - Taken: increment, holding at 2**CNT_WIDTH-1.
  - Not taken: decrement, holding at 0.
  - Prediction is the counter MSB.
- Table update, when `en && update_valid`: `table[update_index] <= sat(table[update_index], update_taken)`.
- Bypass: on `update_valid && update_index == pred_index` in the same cycle, `pred_taken` uses the post-update counter value.
- GHR priority, applied when `en`:
  1. `update_valid && update_mispredict`: `ghr <= {update_ghr[GHR_WIDTH-2:0], update_taken}`. This wins over a same-cycle lookup, and that lookup's shift is discarded.
  2. Else `lookup_valid`: `ghr <= {ghr[GHR_WIDTH-2:0], pred_taken}`.
  3. Else hold.
- GHR_WIDTH=1 degenerates to `ghr <= taken bit`.
- `update_mispredict` is ignored when `update_valid` is low.
- Lookup with `lookup_valid` low still drives the outputs combinationally; only the GHR shift is gated.

## Timing
- Lookup outputs are combinational from `lookup_pc`, the table and `ghr`: zero-cycle latency.
- Table writes and GHR changes become visible one cycle after the edge.
- Reset values (apply at the first edge with `rst` high; `rst` overrides `en`):
  - Every entry = 2**(CNT_WIDTH-1)-1 (weakly not-taken).
  - `ghr` = 0.
  - Hence `pred_taken` = 0, `pred_ghr` = 0, `pred_index` = `lookup_pc`.
- Reset asserted mid-stream discards in-flight updates presented in that cycle.
- Back-to-back updates to the same index in consecutive cycles each see the previous cycle's write (no lost update).

## Configuration
- `GSHARE_HASH_EN` defined: XOR hash as above.
- `GSHARE_HASH_EN` undefined: bimodal mode.
  - `pred_index = lookup_pc`.
  - GHR is still maintained and output, so the pipeline interface is unchanged.

## Structure
- Package `bp_pkg` holds:
  - Counter typedef parameterised by CNT_WIDTH.
  - Weak-not-taken init constant function.
  - Saturation bounds.
- Sub-module `sat_counter` (CNT_WIDTH param): pure next-state function `(cnt, taken) -> next`.
  - Instanced once on the update path.
  - Its output is reused for the bypass compare.
- Table is a flat register array so the reset loads every entry in one cycle.

## Test plan
All cases use defaults and `GSHARE_HASH_EN` defined.
- Reset, then lookup_pc=0x155 -> `pred_taken`=0, `pred_index`=0x155, `ghr`=0.
- Three taken updates to index 0x155 -> counter 1→2→3→3 (saturates); lookup next cycle gives `pred_taken`=1.
- Update taken at index 0x0AA (counter 1→2) concurrent with a lookup hashing to 0x0AA -> `pred_taken`=1 in the same cycle (bypass).
- Lookups with predictions 1,0,1 from `ghr`=0 -> `ghr`=0x05; then lookup_pc=0x100 -> `pred_index`=0x105.
- `ghr`=0x3C, update mispredict with `update_ghr`=0x12 and `update_taken`=1, plus a concurrent lookup -> `ghr`=0x25 next cycle; lookup shift dropped.
- `en`=0 with update and lookup valid -> table and `ghr` unchanged; `rst` with `en`=0 still reinitialises.
